// File: rtl/digit_serial_addsub_pkg.sv
// Shared definitions for the digit-serial adder/subtractor: FSM state encoding
// and the counter-width helper.
package digit_serial_addsub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // A single-digit configuration still needs a one-bit counter.
  function automatic int cnt_width(input int ndig);
    return (ndig <= 2) ? 1 : $clog2(ndig);
  endfunction

endpackage

// File: rtl/digit_serial_addsub_if.sv
// START/BUSY/DONE handshake plus operand and result bus between the control unit
// and the digit-serial adder/subtractor.
interface digit_serial_addsub_if #(
  parameter int WIDTH = 16
) ();

  logic             start;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] w;
  logic             cout;
  logic             ovf;

  modport master (
    output start, sub, cin, x, y,
    input  busy, done, w, cout, ovf
  );

  modport slave (
    input  start, sub, cin, x, y,
    output busy, done, w, cout, ovf
  );

endinterface

// File: rtl/digit_serial_addsub_add_chunk.sv
// DIGIT-wide ripple of full-adder cells; also exposes the carry into its top bit
// so the parent can form the signed-overflow term.
module add_chunk #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             cin,
  output logic [DIGIT-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic carry;

  always_comb begin
    carry = cin;
    cmsb  = cin;
    s     = '0;
    for (int i = 0; i < DIGIT; i++) begin
      if (i == DIGIT - 1) cmsb = carry;
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    cout = carry;
  end

endmodule

// File: rtl/digit_serial_addsub.sv
// Multi-cycle adder/subtractor: consumes DIGIT bits per clock, LSB digit first,
// using a single DIGIT-wide adder chunk behind a START/BUSY/DONE handshake.
module digit_serial_addsub
  import digit_serial_addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  digit_serial_addsub_if.slave bus
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = cnt_width(NDIG);
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_params
    $fatal(1, "digit_serial_addsub: WIDTH must be >= 2 and a multiple of DIGIT");
  end

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] res;
  logic [WIDTH-1:0] res_next;
  logic             c;
  logic [DIGIT-1:0] s;
  logic             c_next;
  logic             cmsb;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] w;
  logic             cout;
  logic             ovf;

  add_chunk #(.DIGIT(DIGIT)) u_chunk (
    .a    (a[DIGIT-1:0]),
    .b    (b[DIGIT-1:0]),
    .cin  (c),
    .s    (s),
    .cout (c_next),
    .cmsb (cmsb)
  );

  // New digits enter at the top so the LSB digit ends up at bit 0 after NDIG shifts.
  always_comb begin
    res_next = (res >> DIGIT) | (WIDTH'(s) << (WIDTH - DIGIT));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= '0;
      a     <= '0;
      b     <= '0;
      res   <= '0;
      c     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
      w     <= '0;
      cout  <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        RUN: begin
          a   <= a >> DIGIT;
          b   <= b >> DIGIT;
          c   <= c_next;
          res <= res_next;
          cnt <= cnt + CW'(1);
          if (cnt == LAST) begin
            w     <= res_next;
            cout  <= c_next;
            ovf   <= cmsb ^ c_next;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= FIN;
          end
        end
        default: begin
          // Subtraction is X + ~Y + ~borrow, so the same chunk serves both modes.
          if (bus.start) begin
            a     <= bus.x;
            b     <= bus.sub ? ~bus.y : bus.y;
            c     <= bus.cin ^ bus.sub;
            res   <= '0;
            cnt   <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign bus.busy = busy;
  assign bus.done = done;
  assign bus.w    = w;
  assign bus.cout = cout;
  assign bus.ovf  = ovf;

endmodule

// File: tb/tb_digit_serial_addsub.sv
// Bench for digit_serial_addsub: three instances (DIGIT = 4, 16, 1) share one
// stimulus stream and are each tracked by an arithmetic reference model.
module tb_digit_serial_addsub;

  localparam int WIDTH = 16;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        sub   = 1'b0;
  logic        cin   = 1'b0;
  logic [15:0] x     = '0;
  logic [15:0] y     = '0;

  logic        busy_v [3];
  logic        done_v [3];
  logic        cout_v [3];
  logic        ovf_v  [3];
  logic [15:0] w_v    [3];

  int total  = 0;
  int passed = 0;
  bit chk_on = 1'b0;

  always #5 clk = ~clk;

  function automatic int ndOf(input int g);
    return (g == 0) ? 4 : ((g == 1) ? 1 : 16);
  endfunction

  // Returns {ovf, cout, w} from plain integer arithmetic.
  function automatic logic [17:0] predict(input logic s, input logic [15:0] xx,
                                          input logic [15:0] yy, input logic c);
    longint ux, uy, sx, sy, u, sv;
    logic   co, ov;
    logic [15:0] r;
    ux = longint'(xx);
    uy = longint'(yy);
    sx = longint'($signed(xx));
    sy = longint'($signed(yy));
    if (!s) begin
      u  = ux + uy + longint'(c);
      sv = sx + sy + longint'(c);
      co = (u >= 65536);
    end else begin
      u  = ux - uy - longint'(c);
      sv = sx - sy - longint'(c);
      co = (ux >= uy + longint'(c));
    end
    r  = u[15:0];
    ov = (sv > 32767) || (sv < -32768);
    return {ov, co, r};
  endfunction

  function automatic logic [15:0] pick();
    case ($urandom % 6)
      0:       return 16'h0000;
      1:       return 16'hFFFF;
      2:       return 16'h7FFF;
      3:       return 16'h8000;
      default: return 16'($urandom);
    endcase
  endfunction

  for (genvar g = 0; g < 3; g++) begin : cfg
    localparam int DG = (g == 0) ? 4 : ((g == 1) ? 16 : 1);
    localparam int ND = WIDTH / DG;

    digit_serial_addsub_if #(.WIDTH(WIDTH)) ifc ();

    assign ifc.start = start;
    assign ifc.sub   = sub;
    assign ifc.cin   = cin;
    assign ifc.x     = x;
    assign ifc.y     = y;

    digit_serial_addsub #(.WIDTH(WIDTH), .DIGIT(DG)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc.slave)
    );

    assign busy_v[g] = ifc.busy;
    assign done_v[g] = ifc.done;
    assign cout_v[g] = ifc.cout;
    assign ovf_v[g]  = ifc.ovf;
    assign w_v[g]    = ifc.w;

    logic        m_busy = 1'b0;
    logic        m_done = 1'b0;
    logic        m_cout = 1'b0;
    logic        m_ovf  = 1'b0;
    logic [15:0] m_w    = '0;
    logic [17:0] pend   = '0;
    int          left   = 0;

    // An accepted request completes exactly ND edges after the launch edge.
    always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        m_busy <= 1'b0;
        m_done <= 1'b0;
        m_cout <= 1'b0;
        m_ovf  <= 1'b0;
        m_w    <= '0;
        left   <= 0;
      end else begin
        m_done <= 1'b0;
        if (left != 0) begin
          left <= left - 1;
          if (left == 1) begin
            m_w    <= pend[15:0];
            m_cout <= pend[16];
            m_ovf  <= pend[17];
            m_done <= 1'b1;
            m_busy <= 1'b0;
          end
        end else if (start) begin
          pend   <= predict(sub, x, y, cin);
          left   <= ND;
          m_busy <= 1'b1;
        end
      end
    end

    always @(negedge clk) begin
      if (chk_on) begin
        total++;
        if ({ifc.busy, ifc.done, ifc.cout, ifc.ovf, ifc.w} ===
            {m_busy, m_done, m_cout, m_ovf, m_w}) begin
          passed++;
        end else begin
          $display("[TB] FAIL cycle[%0d] t=%0t: got busy=%b done=%b w=%h cout=%b ovf=%b, required busy=%b done=%b w=%h cout=%b ovf=%b",
                   g, $time, ifc.busy, ifc.done, ifc.w, ifc.cout, ifc.ovf,
                   m_busy, m_done, m_w, m_cout, m_ovf);
        end
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act === req) passed++;
    else $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
  endtask

  // Presents one request for the launch edge, then scrambles the operands.
  task automatic applyStimulus(input logic s, input logic [15:0] xx, input logic [15:0] yy,
                               input logic c);
    @(negedge clk);
    start = 1'b1;
    sub   = s;
    x     = xx;
    y     = yy;
    cin   = c;
    @(posedge clk);
    #1;
    start = 1'b0;
    sub   = 1'($urandom);
    x     = 16'($urandom);
    y     = 16'($urandom);
    cin   = 1'($urandom);
  endtask

  task automatic runAll(input string name, input logic s, input logic [15:0] xx,
                        input logic [15:0] yy, input logic c, input logic [15:0] ew,
                        input logic ec, input logic eo);
    int lat [3];
    int bcnt [3];
    foreach (lat[g]) begin
      lat[g]  = 0;
      bcnt[g] = 0;
    end
    applyStimulus(s, xx, yy, c);
    for (int g = 0; g < 3; g++) if (busy_v[g]) bcnt[g]++;
    for (int n = 2; n <= 40 && !(lat[0] != 0 && lat[1] != 0 && lat[2] != 0); n++) begin
      @(posedge clk);
      #1;
      for (int g = 0; g < 3; g++) begin
        if (done_v[g] && lat[g] == 0) lat[g] = n;
        else if (busy_v[g] && lat[g] == 0) bcnt[g]++;
      end
    end
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("%s latency[%0d]", name, g), 32'(lat[g]), 32'(ndOf(g) + 1));
      checkOutput($sformatf("%s busy_cycles[%0d]", name, g), 32'(bcnt[g]), 32'(ndOf(g)));
      checkOutput($sformatf("%s w[%0d]", name, g), 32'(w_v[g]), 32'(ew));
      checkOutput($sformatf("%s cout_ovf[%0d]", name, g), {30'd0, cout_v[g], ovf_v[g]},
                  {30'd0, ec, eo});
    end
  endtask

  initial begin
    int edges, hold_bad, dcount;
    #12;
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("reset flags[%0d]", g),
                  {28'd0, busy_v[g], done_v[g], cout_v[g], ovf_v[g]}, 32'd0);
      checkOutput($sformatf("reset w[%0d]", g), 32'(w_v[g]), 32'd0);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    chk_on = 1'b1;

    checkOutput("model add", 32'(predict(1'b0, 16'h1234, 16'h1111, 1'b0)), 32'h0_2345);
    checkOutput("model sub", 32'(predict(1'b1, 16'h0005, 16'h0007, 1'b0)), 32'h0_FFFE);
    checkOutput("model ovf", 32'(predict(1'b1, 16'h8000, 16'h0001, 1'b0)), 32'h3_7FFF);

    runAll("add",     1'b0, 16'h1234, 16'h1111, 1'b0, 16'h2345, 1'b0, 1'b0);
    runAll("carry",   1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
    runAll("ovf_add", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
    runAll("sub",     1'b1, 16'h0005, 16'h0007, 1'b0, 16'hFFFE, 1'b0, 1'b0);
    runAll("ovf_sub", 1'b1, 16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b1, 1'b1);
    runAll("cin",     1'b0, 16'hABCD, 16'h1111, 1'b1, 16'hBCDF, 1'b0, 1'b0);

    // Mid-run request is ignored, then a request in the DONE cycle is taken at once.
    applyStimulus(1'b0, 16'h0001, 16'h0001, 1'b0);
    @(negedge clk);
    start = 1'b1; sub = 1'b0; x = 16'h00FF; y = 16'h0001; cin = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int k = 0; k < 10 && !done_v[0]; k++) begin
      @(posedge clk);
      #1;
    end
    checkOutput("ignored done", 32'(done_v[0]), 32'd1);
    checkOutput("ignored w", 32'(w_v[0]), 32'h0002);
    start = 1'b1; sub = 1'b0; x = 16'h0010; y = 16'h0020; cin = 1'b0;
    @(posedge clk);
    #1;
    start    = 1'b0;
    edges    = 1;
    hold_bad = 0;
    for (int k = 0; k < 20 && !done_v[0]; k++) begin
      @(posedge clk);
      #1;
      edges++;
      if (!done_v[0] && w_v[0] !== 16'h0002) hold_bad++;
    end
    checkOutput("b2b latency", 32'(edges), 32'd5);
    checkOutput("b2b w hold", 32'(hold_bad), 32'd0);
    checkOutput("b2b w", 32'(w_v[0]), 32'h0030);
    repeat (40) @(negedge clk);

    // Reset in the second RUN cycle aborts everything immediately.
    applyStimulus(1'b0, 16'h1234, 16'h0001, 1'b0);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    for (int g = 0; g < 3; g++) begin
      checkOutput($sformatf("abort flags[%0d]", g),
                  {28'd0, busy_v[g], done_v[g], cout_v[g], ovf_v[g]}, 32'd0);
      checkOutput($sformatf("abort w[%0d]", g), 32'(w_v[g]), 32'd0);
    end
    @(negedge clk);
    rst_n  = 1'b1;
    dcount = 0;
    for (int k = 0; k < 25; k++) begin
      @(posedge clk);
      #1;
      if (done_v[0]) dcount++;
    end
    checkOutput("abort no done", 32'(dcount), 32'd0);
    runAll("after_reset", 1'b0, 16'h0010, 16'h0020, 1'b0, 16'h0030, 1'b0, 1'b0);

    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      start = ($urandom % 3) != 0;
      sub   = 1'($urandom);
      cin   = 1'($urandom);
      x     = pick();
      y     = pick();
    end
    @(negedge clk);
    start = 1'b0;
    repeat (40) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got timeout, required completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
